// File: rtl/sd_loader_pio_edge_in_pkg.sv
// Shared definitions for the SD-loader edge-capturing input PIO:
// register word addresses and the edge-capture MODE encodings.
package sd_loader_pio_edge_in_pkg;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MODE = 2'd1;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    typedef enum logic [1:0] {
        MODE_OFF  = 2'b00,
        MODE_RISE = 2'b01,
        MODE_FALL = 2'b10,
        MODE_ANY  = 2'b11
    } mode_e;

endpackage

// File: rtl/sd_loader_pio_sync_edge.sv
// Per-bit synchroniser chain, one-cycle history flop and edge selection.
// sync is the last synchroniser stage; edge_flags is combinational from
// sync/prev and the current capture mode.
module sd_loader_pio_sync_edge
    import sd_loader_pio_edge_in_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_port,
    input  mode_e            mode,
    output logic [WIDTH-1:0] sync,
    output logic [WIDTH-1:0] edge_flags
);

    logic [WIDTH-1:0] stage [SYNC_STAGES];
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;

    // Shift the asynchronous inputs through the synchroniser chain
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign sync = stage[SYNC_STAGES-1];

    // Hold last cycle's synchronised value; zero after reset so an input
    // that is already high shows up as a rising edge once the chain fills
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev <= '0;
        end else begin
            prev <= sync;
        end
    end

    assign rise = sync & ~prev;
    assign fall = ~sync & prev;

    // Pick which transitions count as an edge for the current mode
    always_comb begin
        edge_flags = '0;
        case (mode)
            MODE_RISE: edge_flags = rise;
            MODE_FALL: edge_flags = fall;
            MODE_ANY:  edge_flags = rise | fall;
            default:   edge_flags = '0;
        endcase
    end

endmodule

// File: rtl/sd_loader_pio_edge_in.sv
// Avalon-MM input PIO for the SD-loader subsystem: synchronised level
// readback, sticky per-bit edge flags (write-1-to-clear), per-bit IRQ
// mask and a registered level interrupt. readdata is registered every
// cycle from the address mux, so reads need no strobe and see register
// state from before any same-cycle write.
module sd_loader_pio_edge_in
    import sd_loader_pio_edge_in_pkg::*;
#(
    parameter int               WIDTH       = 16,
    parameter int               SYNC_STAGES = 2,
    parameter logic [1:0]       RESET_MODE  = 2'b01,
    parameter logic [WIDTH-1:0] RESET_MASK  = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             chipselect,
    input  logic [1:0]       address,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    mode_e            mode_q;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] cap_q;
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] edge_flags;
    logic [WIDTH-1:0] clr;
    logic             wr_en;
    logic [31:0]      rd_next;

    // Upper write-data bits have no storage behind them
    if (WIDTH < 32) begin : g_wdata_upper
        logic unused_wdata;
        assign unused_wdata = ^writedata[31:WIDTH];
    end

    sd_loader_pio_sync_edge #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_port    (in_port),
        .mode       (mode_q),
        .sync       (sync),
        .edge_flags (edge_flags)
    );

    assign wr_en = chipselect & ~write_n;
    assign clr   = (wr_en && (address == ADDR_EDGE)) ? writedata[WIDTH-1:0] : '0;

    // MODE and IRQ_MASK configuration registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_q <= mode_e'(RESET_MODE);
            mask_q <= RESET_MASK;
        end else if (wr_en) begin
            if (address == ADDR_MODE) begin
                mode_q <= mode_e'(writedata[1:0]);
            end
            if (address == ADDR_MASK) begin
                mask_q <= writedata[WIDTH-1:0];
            end
        end
    end

    // Sticky edge flags; a new edge wins over a same-cycle clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cap_q <= '0;
        end else begin
            cap_q <= (cap_q & ~clr) | edge_flags;
        end
    end

    // Level interrupt from any unmasked captured edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq <= 1'b0;
        end else begin
            irq <= |(cap_q & mask_q);
        end
    end

    // Read mux, zero-extended to the bus width
    always_comb begin
        rd_next = '0;
        case (address)
            ADDR_DATA: rd_next[WIDTH-1:0] = sync;
            ADDR_MODE: rd_next[1:0]       = mode_q;
            ADDR_MASK: rd_next[WIDTH-1:0] = mask_q;
            ADDR_EDGE: rd_next[WIDTH-1:0] = cap_q;
            default:   rd_next            = '0;
        endcase
    end

    // Registered read data, one cycle of latency
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= rd_next;
        end
    end

endmodule
